// File: rtl/median_pkg.sv
// Shared definitions for the 3x3 median block: controller state encoding,
// default image geometry and the datapath latency the sync delays must match.
package median_pkg;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int MEDIAN_LATENCY = 9;
  localparam int DEF_FLUSH_CYC  = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FLUSH     = 3'd1,
    ST_WAIT_LINE = 3'd2,
    ST_LINE      = 3'd3,
    ST_FRAME_END = 3'd4
  } ctrl_state_t;

  // Column counter increment that parks at the last valid column.
  function automatic logic [9:0] sat_inc10(input logic [9:0] val, input logic [9:0] max_val);
    return (val >= max_val) ? max_val : val + 10'd1;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Reset-to-zero shift register used to align sync and window-valid flags
// with the median datapath output. DEPTH of 0 is a straight wire.
module sync_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] sr [DEPTH];

      always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
          sr[0] <= din;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end

      assign dout = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/median_window_ctrl.sv
// Frame/line timing controller for the 3x3 median datapath: line-buffer
// enables and flush, window-valid flag and latency-matched syncs.
// Optional line-length checker enabled by defining MEDIAN_CTRL_LEN_CHECK_EN.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | waiting for a frame start (vs rising edge)
// ST_FLUSH     | line buffers held in reset for FLUSH_CYC cycles
// ST_WAIT_LINE | between lines, first de-high pixel starts the line
// ST_LINE      | counting pixels of the current line
// ST_FRAME_END | one-cycle frame_done after the last line
module median_window_ctrl
  import median_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int LATENCY   = MEDIAN_LATENCY,
  parameter int FLUSH_CYC = DEF_FLUSH_CYC
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       in_hs,
  input  logic       in_vs,
  input  logic       in_de,
  output logic       lb_wr_en,
  output logic       lb_rd_en,
  output logic       lb_rst,
  output logic [9:0] col_cnt,
  output logic [8:0] row_cnt,
  output logic       out_hs,
  output logic       out_vs,
  output logic       out_de,
  output logic       out_win_valid,
  output logic       frame_done,
  output logic       line_err
);

  localparam logic [9:0] COL_MAX    = 10'(H_ACTIVE - 1);
  localparam logic [8:0] ROW_LAST   = 9'(V_ACTIVE - 1);
  localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYC - 1);

  ctrl_state_t state, state_nxt;
  logic [7:0]  flush_cnt, flush_cnt_nxt;
  logic [9:0]  col_nxt;
  logic [8:0]  row_nxt;
  logic        vs_q, de_q;
  logic        vs_rise, de_fall;
  logic        pix_en;
  logic        win_in, win_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
      de_q <= 1'b0;
    end else begin
      vs_q <= in_vs;
      de_q <= in_de;
    end
  end

  assign vs_rise = in_vs & ~vs_q;
  assign de_fall = ~in_de & de_q;

  // Pixels are only accepted between lines or inside a line; the WAIT_LINE
  // pixel that starts a line is column 0 and is enabled in the same cycle.
  assign pix_en   = in_de & ((state == ST_LINE) | (state == ST_WAIT_LINE));
  assign lb_wr_en = pix_en;
  assign lb_rd_en = pix_en;
  assign lb_rst     = (state == ST_FLUSH);
  assign frame_done = (state == ST_FRAME_END);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      flush_cnt <= 8'd0;
      col_cnt   <= 10'd0;
      row_cnt   <= 9'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      col_cnt   <= col_nxt;
      row_cnt   <= row_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    col_nxt       = col_cnt;
    row_nxt       = row_cnt;

    if (pix_en) col_nxt = sat_inc10(col_cnt, COL_MAX);

    case (state)
      ST_IDLE: ;
      ST_FLUSH: begin
        col_nxt = 10'd0;
        row_nxt = 9'd0;
        if (flush_cnt == 8'd0) state_nxt = ST_WAIT_LINE;
        else                   flush_cnt_nxt = flush_cnt - 8'd1;
      end
      ST_WAIT_LINE: begin
        if (in_de) state_nxt = ST_LINE;
      end
      ST_LINE: begin
        if (de_fall) begin
          col_nxt = 10'd0;
          if (row_cnt == ROW_LAST) begin
            row_nxt   = 9'd0;
            state_nxt = ST_FRAME_END;
          end else begin
            row_nxt   = row_cnt + 9'd1;
            state_nxt = ST_WAIT_LINE;
          end
        end
      end
      ST_FRAME_END: state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase

    // A frame start wins over everything, including a line in progress.
    if (vs_rise) begin
      state_nxt     = ST_FLUSH;
      flush_cnt_nxt = FLUSH_LOAD;
      col_nxt       = 10'd0;
      row_nxt       = 9'd0;
    end
  end

  // Window centred at (row-1, col-1) needs two lines and two columns behind it.
  assign win_in = pix_en & (row_cnt >= 9'd2) & (col_cnt >= 10'd2);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) win_q <= 1'b0;
    else        win_q <= win_in;
  end

  sync_delay_line #(.WIDTH(3), .DEPTH(LATENCY)) u_sync_dly (
    .pclk  (pclk),
    .rst_n (rst_n),
    .din   ({in_hs, in_vs, in_de}),
    .dout  ({out_hs, out_vs, out_de})
  );

  sync_delay_line #(.WIDTH(1), .DEPTH(LATENCY - 1)) u_win_dly (
    .pclk  (pclk),
    .rst_n (rst_n),
    .din   (win_q),
    .dout  (out_win_valid)
  );

`ifdef MEDIAN_CTRL_LEN_CHECK_EN
  // Separate length counter: col_cnt saturates and cannot see overlong lines.
  logic [10:0] len_cnt;
  logic        line_err_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      len_cnt    <= 11'd0;
      line_err_q <= 1'b0;
    end else if (vs_rise) begin
      len_cnt    <= 11'd0;
      line_err_q <= 1'b0;
    end else if ((state == ST_LINE) && de_fall) begin
      len_cnt    <= 11'd0;
      line_err_q <= line_err_q | (len_cnt != 11'(H_ACTIVE));
    end else if (state == ST_FLUSH) begin
      len_cnt <= 11'd0;
    end else if (pix_en && (len_cnt != 11'h7FF)) begin
      len_cnt <= len_cnt + 11'd1;
    end
  end

  assign line_err = line_err_q;
`else
  assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_median_window_ctrl.sv
// Scoreboard bench for median_window_ctrl with an 8x6 image: stimulus pushes
// expected delayed syncs and window flags, a negedge monitor pops and compares.
module tb_median_window_ctrl;

  localparam int H   = 8;
  localparam int V   = 6;
  localparam int LAT = 9;
  localparam int FL  = 4;
`ifdef MEDIAN_CTRL_LEN_CHECK_EN
  localparam int LE = 1;
`else
  localparam int LE = 0;
`endif

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_hs = 1'b0, in_vs = 1'b0, in_de = 1'b0;
  logic       lb_wr_en, lb_rd_en, lb_rst;
  logic [9:0] col_cnt;
  logic [8:0] row_cnt;
  logic       out_hs, out_vs, out_de, out_win_valid, frame_done, line_err;

  median_window_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .LATENCY(LAT), .FLUSH_CYC(FL)) dut (
    .pclk          (pclk),
    .rst_n         (rst_n),
    .in_hs         (in_hs),
    .in_vs         (in_vs),
    .in_de         (in_de),
    .lb_wr_en      (lb_wr_en),
    .lb_rd_en      (lb_rd_en),
    .lb_rst        (lb_rst),
    .col_cnt       (col_cnt),
    .row_cnt       (row_cnt),
    .out_hs        (out_hs),
    .out_vs        (out_vs),
    .out_de        (out_de),
    .out_win_valid (out_win_valid),
    .frame_done    (frame_done),
    .line_err      (line_err)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic hs;
    logic vs;
    logic de;
  } sync_rec_t;

  sync_rec_t sync_q[$];
  logic      win_q[$];
  sync_rec_t mon_rec;
  logic      mon_win;
  int checks = 0, errors = 0;
  int win_seen = 0, lr_seen = 0, fd_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge pclk) begin
    if (rst_n) begin
      if (sync_q.size() > 0 && sync_q[0].cyc <= cyc) begin
        mon_rec = sync_q.pop_front();
        check("sync_cycle", cyc, mon_rec.cyc);
        check("out_hs", int'(out_hs), int'(mon_rec.hs));
        check("out_vs", int'(out_vs), int'(mon_rec.vs));
        check("out_de", int'(out_de), int'(mon_rec.de));
      end
      if (out_de) begin
        check("win_queue_nonempty", int'(win_q.size() > 0), 1);
        if (win_q.size() > 0) begin
          mon_win = win_q.pop_front();
          check("out_win_valid", int'(out_win_valid), int'(mon_win));
        end
      end else begin
        check("win_needs_de", int'(out_win_valid), 0);
      end
      if (out_win_valid) win_seen++;
    end
  end

  task automatic tick(input logic hs, input logic vs, input logic de, input logic win);
    @(posedge pclk);
    #1;
    in_hs = hs;
    in_vs = vs;
    in_de = de;
    sync_q.push_back('{cyc + LAT, hs, vs, de});
    if (de) win_q.push_back(win);
    #1;
    lr_seen += int'(lb_rst);
    fd_seen += int'(frame_done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_frame();
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= FL + 2; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("flush_lb_rst", int'(lb_rst), int'(i <= FL));
      check("flush_col", int'(col_cnt), 0);
      check("flush_row", int'(row_cnt), 0);
    end
  endtask

  task automatic run_line(input int r, input int n, input int next_row);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("line_start_col", int'(col_cnt), 0);
    for (int c = 0; c < n; c++) begin
      tick(1'b0, 1'b0, 1'b1, (r >= 2) && (c >= 2));
      check("col_cnt", int'(col_cnt), (c < H - 1) ? c : H - 1);
      check("row_cnt", int'(row_cnt), r);
      check("lb_wr_en", int'(lb_wr_en), 1);
      check("lb_rd_en", int'(lb_rd_en), 1);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("col_at_fall", int'(col_cnt), (n < H - 1) ? n : H - 1);
    check("lb_wr_gap", int'(lb_wr_en), 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("col_after_fall", int'(col_cnt), 0);
    check("row_after_fall", int'(row_cnt), next_row);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;

  initial begin
    // 1: reset holds every output low while inputs toggle
    for (int i = 0; i < 8; i++) begin
      @(posedge pclk);
      #1;
      in_hs = i[0];
      in_vs = i[1];
      in_de = ~i[0];
      #1;
      check("rst_flags", int'({lb_wr_en, lb_rd_en, lb_rst, out_hs, out_vs, out_de,
                               out_win_valid, frame_done, line_err}), 0);
      check("rst_col", int'(col_cnt), 0);
      check("rst_row", int'(row_cnt), 0);
    end
    in_hs = 1'b0; in_vs = 1'b0; in_de = 1'b0;
    @(negedge pclk);
    rst_n = 1'b1;
    lr_seen = 0; fd_seen = 0;
    idle(5);
    check("idle_lb_rst_cycles", lr_seen, 0);
    check("idle_frame_done", fd_seen, 0);

    // 2: full frame
    base = win_seen;
    lr_seen = 0; fd_seen = 0;
    start_frame();
    for (int r = 0; r < V; r++) run_line(r, H, (r < V - 1) ? r + 1 : 0);
    idle(2);
    check("frame_lb_rst_cycles", lr_seen, FL);
    check("frame_done_pulses", fd_seen, 1);
    check("frame_line_err", int'(line_err), 0);
    idle(12);
    check("frame_win_count", win_seen - base, 24);

    // 3: vs rise on line 3, column 4
    base = win_seen;
    start_frame();
    for (int r = 0; r < 3; r++) run_line(r, H, r + 1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, 1'b1, c >= 2);
    lr_seen = 0; fd_seen = 0;
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    check("abort_col", int'(col_cnt), 4);
    check("abort_row", int'(row_cnt), 3);
    for (int k = 1; k <= FL + 1; k++) begin
      tick(1'b0, 1'b0, k <= 3, 1'b0);
      check("abort_lb_rst", int'(lb_rst), int'(k <= FL));
      check("abort_wr_en", int'(lb_wr_en), 0);
      check("abort_col_clr", int'(col_cnt), 0);
      check("abort_row_clr", int'(row_cnt), 0);
    end
    idle(3);
    check("abort_lb_rst_cycles", lr_seen, FL);
    check("abort_no_frame_done", fd_seen, 0);
    idle(12);
    check("abort_win_count", win_seen - base, 9);

    // 4: de pulses during flush are ignored
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= FL; k++) begin
      tick(1'b0, 1'b0, k[0], 1'b0);
      check("flush_de_lb_rst", int'(lb_rst), 1);
      check("flush_de_wr_en", int'(lb_wr_en), 0);
      check("flush_de_rd_en", int'(lb_rd_en), 0);
      check("flush_de_col", int'(col_cnt), 0);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("flush_de_done", int'(lb_rst), 0);

    // 5/6: short line then long line, line_err only with the checker built in
    run_line(0, 7, 1);
    check("short_line_err", int'(line_err), LE);
    run_line(1, 10, 2);
    check("long_line_err", int'(line_err), LE);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("line_err_before_clear", int'(line_err), LE);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("line_err_cleared", int'(line_err), 0);
    idle(FL + 12);
    check("win_queue_drained", win_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
